// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// The optional IFQ_PERF_EN build adds fetch/flush counters to the top.
package if_prefetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One queued fetch: {pc, pc_4, instr}, 96 bits packed.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // Sequential PC; wraps at 2^32.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry ring buffer of fetch entries with push, pop, flush,
// occupancy count and combinational head data.
module ifq_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_push,
    input  ifq_entry_t                     i_push_data,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output ifq_entry_t                     o_head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    ifq_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // Pops only from a non-empty buffer; pushes only with space (or a same-cycle pop).
    always_comb begin
        w_pop  = i_pop & (r_count != '0) & ~i_flush;
        w_push = i_push & ~i_flush & ((r_count != CW'(DEPTH)) | w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_count = r_count;
        o_head  = r_mem[r_head];
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetch PC, single in-flight request tracking,
// credit-based issue and redirect flush. IFQ_PERF_EN adds fetch_cnt/flush_cnt.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_4,
    output logic [XLEN-1:0] out_instr
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_inflight_pc;
    logic            r_inflight;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    logic            w_push;
    logic            w_pop;
    ifq_entry_t      w_push_data;
    ifq_entry_t      w_head;

    // Issue only while queued + in-flight entries leave room; a redirect kills the returning word.
    always_comb begin
        w_used      = {1'b0, w_count} + (CW+1)'(r_inflight);
        imem_req    = ~reset & ~redirect & (w_used < (CW+1)'(DEPTH));
        imem_addr   = r_fpc;
        w_push      = r_inflight & ~redirect;
        w_pop       = out_valid & out_ready;
        w_push_data = '{pc: r_inflight_pc, pc_4: pc_next(r_inflight_pc), instr: imem_rdata};
        out_valid   = (w_count != '0);
        out_pc      = w_head.pc;
        out_pc_4    = w_head.pc_4;
        out_instr   = w_head.instr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inflight_pc <= r_fpc;
                r_fpc         <= pc_next(r_fpc);
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_head      (w_head)
    );

`ifdef IFQ_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (imem_req && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue against a queue-based reference model.
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_4;
    logic [31:0] out_instr;
`ifdef IFQ_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_4    (out_pc_4),
        .out_instr   (out_instr)
`ifdef IFQ_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } m_ent_t;

    int          checks = 0;
    int          errors = 0;
    m_ent_t      m_q[$];
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_rdata_next;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc        = RESET_PC;
        m_infl       = 1'b0;
        m_infl_pc    = '0;
        m_rdata_next = $urandom();
        m_fetch      = '0;
        m_flush      = '0;
    endtask

    // One cycle: called just after a falling edge, returns just after the next one.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic exp_req;
        logic pop;
        logic push;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        imem_rdata  = m_rdata_next;
        #1;
        exp_req = !rd && ((m_q.size() + (m_infl ? 1 : 0)) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_fpc);
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_pc_4", out_pc_4, m_q[0].pc + 32'd4);
            check("out_instr", out_instr, m_q[0].instr);
        end
        pop  = (m_q.size() > 0) && rdy;
        push = m_infl && !rd;
        if (rd) begin
            m_q.delete();
            m_fpc        = rpc;
            m_infl       = 1'b0;
            m_rdata_next = $urandom();
            if (m_flush != '1) m_flush++;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{pc: m_infl_pc, instr: memfn(m_infl_pc)});
            if (exp_req) begin
                m_infl       = 1'b1;
                m_infl_pc    = m_fpc;
                m_rdata_next = memfn(m_fpc);
                m_fpc        = m_fpc + 32'd4;
                if (m_fetch != '1) m_fetch++;
            end else begin
                m_infl       = 1'b0;
                m_rdata_next = $urandom();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges, spanning one rising edge.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        check("rst_async_imem_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        imem_rdata  = '0;
        model_reset();
        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_imem_req", 32'(imem_req), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);

        // Streaming from RESET_PC with a ready consumer.
        check("first_addr", imem_addr, RESET_PC);
        repeat (6) step(1'b0, '0, 1'b1);

        // Back-pressure fills the queue, then one pop frees one credit.
        repeat (8) step(1'b0, '0, 1'b0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_no_req", 32'(imem_req), 32'd0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Redirect with 3 queued and 1 in flight.
        step(1'b1, 32'h0000_0200, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        check("pre_redirect_depth", 32'(m_q.size()), 32'd3);
        step(1'b1, 32'h0000_0100, 1'b0);
        check("post_redirect_valid", 32'(out_valid), 32'd0);
        check("post_redirect_addr", imem_addr, 32'h0000_0100);
        repeat (4) step(1'b0, '0, 1'b1);

        // Redirect together with a pop and a push in steady flow.
        step(1'b1, 32'h0000_0400, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1);

        // Address wrap across 2^32.
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0) r[31:8] = 24'hFFFFFF;
            r[1:0] = 2'b00;
            step(($urandom_range(0, 9) == 0), r, ($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream, then restart from RESET_PC.
        reset_pulse();
        check("post_reset_addr", imem_addr, RESET_PC);
        repeat (10) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_0800, 1'b1);
        step(1'b1, 32'h0000_0900, 1'b1);
`ifdef IFQ_PERF_EN
        check("fetch_cnt", fetch_cnt, 32'd10);
        check("flush_cnt", flush_cnt, 32'd2);
        check("fetch_cnt_model", fetch_cnt, m_fetch);
        check("flush_cnt_model", flush_cnt, m_flush);
`endif
        repeat (4) step(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
